// File: rtl/sum_n_down_engine.sv
`default_nettype none
// ============================================================================
// Module      : sum_n_down_engine
// Description : Loads a term count N and counts down to zero while
//               accumulating a sum. Mode 0 adds N+(N-1)+...+1 from the down
//               counter itself. Mode 1 adds N words taken from a valid/ready
//               stream. Start/busy/done handshake, sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_n_down_engine #(
    parameter int CW = 4,
    parameter int DW = 8,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic          mode,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [CW-1:0] count,
    output logic [SW-1:0] sum,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_sum;
    logic          r_ovf;
    logic          r_mode;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [SW-1:0] w_sum_nxt;
    logic          w_ovf_nxt;
    logic          w_mode_nxt;

    logic          w_accept;
    logic [SW:0]   w_addend;
    logic [SW:0]   w_add;

    // An add happens every RUN cycle in mode 0, only on a stream handshake in mode 1.
    assign w_accept = (r_state == c_run) && (!r_mode || din_valid);
    assign w_addend = r_mode ? (SW+1)'(din) : (SW+1)'(r_count);
    assign w_add    = {1'b0, r_sum} + w_addend;

    // Next-state and next-datapath values; everything holds unless a transition says otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_sum_nxt   = r_sum;
        w_ovf_nxt   = r_ovf;
        w_mode_nxt  = r_mode;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_count_nxt = n;
                    w_sum_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_mode_nxt  = mode;
                    w_state_nxt = (n == '0) ? c_done : c_run;
                end
            end
            c_run: begin
                if (w_accept) begin
                    w_sum_nxt   = w_add[SW-1:0];
                    w_ovf_nxt   = r_ovf | w_add[SW];
                    w_count_nxt = r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        w_state_nxt = c_done;
                    end
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_count <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sum   <= w_sum_nxt;
            r_ovf   <= w_ovf_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign din_ready = (r_state == c_run) && r_mode;
    assign busy      = (r_state != c_idle);
    assign done      = (r_state == c_done);
    assign count     = r_count;
    assign sum       = r_sum;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_n_down_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_n_down_engine
// Description : Directed self-checking bench for sum_n_down_engine.
//               Observed vector = {busy, done, ovf, din_ready, count, sum}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_n_down_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic       mode;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] count;
    logic [7:0] sum;
    logic       busy;
    logic       done;
    logic       ovf;

    logic [15:0] w_obs;
    int          n_cmp;
    int          n_bad;

    assign w_obs = {busy, done, ovf, din_ready, count, sum};

    sum_n_down_engine #(.CW(4), .DW(8), .SW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .count(count), .sum(sum), .busy(busy), .done(done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); n = 4'($urandom); mode = 1'($urandom);
            din = 8'($urandom); din_valid = 1'($urandom);
            tick();
            n_cmp++;
            if (w_obs !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, w_obs, 16'h0000);
            end
        end
        start = 1'b0; n = '0; mode = 1'b0; din = '0; din_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (w_obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", w_obs, 16'h0000);
        end
    endtask

    task automatic test_mode0_n5();
        logic [3:0] e_cnt [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic [7:0] e_sum [6] = '{8'd0, 8'd5, 8'd9, 8'd12, 8'd14, 8'd15};
        logic [15:0] e;
        start = 1'b1; n = 4'd5; mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            start = 1'b0;
            e = {1'b1, (k == 5), 1'b0, 1'b0, e_cnt[k], e_sum[k]};
            n_cmp++;
            if (w_obs !== e) begin
                n_bad++;
                $display("FAIL mode0_n5[%0d]: got %h want %h", k, w_obs, e);
            end
        end
        tick();
        n_cmp++;
        if (w_obs !== 16'h000F) begin
            n_bad++;
            $display("FAIL mode0_n5_idle: got %h want %h", w_obs, 16'h000F);
        end
    endtask

    task automatic test_n0();
        start = 1'b1; n = 4'd0; mode = 1'b0;
        tick();
        start = 1'b0;
        n_cmp++;
        if (w_obs !== 16'hC000) begin
            n_bad++;
            $display("FAIL n0_done: got %h want %h", w_obs, 16'hC000);
        end
        tick();
        n_cmp++;
        if (w_obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL n0_idle: got %h want %h", w_obs, 16'h0000);
        end
    endtask

    task automatic test_mode1_gaps();
        logic [7:0]  words [3] = '{8'd10, 8'd20, 8'd30};
        logic [7:0]  acc;
        logic [15:0] e;
        acc = 8'd0;
        start = 1'b1; n = 4'd3; mode = 1'b1; din_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int g = 0; g < 2; g++) begin
                din = 8'hEE;
                tick();
                e = {1'b1, 1'b0, 1'b0, 1'b1, 4'(3 - w), acc};
                n_cmp++;
                if (w_obs !== e) begin
                    n_bad++;
                    $display("FAIL mode1_stall[%0d.%0d]: got %h want %h", w, g, w_obs, e);
                end
            end
            din = words[w]; din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            acc = acc + words[w];
            e = (w == 2) ? {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd60}
                         : {1'b1, 1'b0, 1'b0, 1'b1, 4'(2 - w), acc};
            n_cmp++;
            if (w_obs !== e) begin
                n_bad++;
                $display("FAIL mode1_accept[%0d]: got %h want %h", w, w_obs, e);
            end
        end
        tick();
    endtask

    task automatic test_mode1_wrap();
        start = 1'b1; n = 4'd15; mode = 1'b1; din = 8'd255; din_valid = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (w_obs !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 8'd254}) begin
            n_bad++;
            $display("FAIL wrap_mid: got %h want %h", w_obs, {1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 8'd254});
        end
        for (int k = 0; k < 13; k++) tick();
        din_valid = 1'b0;
        n_cmp++;
        if (w_obs !== {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd241}) begin
            n_bad++;
            $display("FAIL wrap_done: got %h want %h", w_obs, {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd241});
        end
        tick();
        n_cmp++;
        if (w_obs !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd241}) begin
            n_bad++;
            $display("FAIL wrap_hold: got %h want %h", w_obs, {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd241});
        end
    endtask

    task automatic test_ovf_clear();
        start = 1'b1; n = 4'd2; mode = 1'b0;
        tick();
        start = 1'b0;
        n_cmp++;
        if (w_obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL ovf_clear: got %h want %h", w_obs, {1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 8'd0});
        end
        tick();
        tick();
        n_cmp++;
        if (w_obs !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3}) begin
            n_bad++;
            $display("FAIL ovf_clear_done: got %h want %h", w_obs, {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3});
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [3:0] e_cnt [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic [7:0] e_sum [6] = '{8'd0, 8'd5, 8'd9, 8'd12, 8'd14, 8'd15};
        logic [15:0] e;
        start = 1'b1; n = 4'd5; mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            start = (k < 2);
            n = 4'd9; mode = 1'b1; din = 8'd7; din_valid = 1'b1;
            e = {1'b1, (k == 5), 1'b0, 1'b0, e_cnt[k], e_sum[k]};
            n_cmp++;
            if (w_obs !== e) begin
                n_bad++;
                $display("FAIL start_ignored[%0d]: got %h want %h", k, w_obs, e);
            end
        end
        start = 1'b0; din_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; n = 4'd8; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if (w_obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 8'd21}) begin
            n_bad++;
            $display("FAIL pre_abort: got %h want %h", w_obs, {1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 8'd21});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_async: got %h want %h", w_obs, 16'h0000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (w_obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_no_done: got %h want %h", w_obs, 16'h0000);
        end
    endtask

    task automatic test_restart();
        start = 1'b1; n = 4'd4; mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if (w_obs !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd10}) begin
            n_bad++;
            $display("FAIL restart_done: got %h want %h", w_obs, {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd10});
        end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; n = '0; mode = 1'b0; din = '0; din_valid = 1'b0;
        test_reset();
        test_mode0_n5();
        test_n0();
        test_mode1_gaps();
        test_mode1_wrap();
        test_ovf_clear();
        test_start_ignored();
        test_reset_mid_run();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
